// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU issue-stage definitions: ALUOp codes, skid states, widths.
// Used by alu_issue_stage, alu_fwd_mux and alu_issue_stage_if.
package alu_pkg;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_NOT = 3'b010;
   localparam logic [2:0] ALU_SLL = 3'b011;
   localparam logic [2:0] ALU_SRL = 3'b100;
   localparam logic [2:0] ALU_AND = 3'b101;
   localparam logic [2:0] ALU_OR  = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_e;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-side, producer-side and ALU-side signals of the issue stage.
// master = decode/pipeline environment, slave = the issue stage.
interface alu_issue_stage_if
   import alu_pkg::*;
#(
   parameter int DATA_W = alu_pkg::DATA_W,
   parameter int REG_AW = alu_pkg::REG_AW
);

   logic              in_valid;
   logic              in_ready;
   logic [2:0]        id_alu_op;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic [REG_AW-1:0] id_rd;
   logic              id_reg_write;
   logic [DATA_W-1:0] id_rdata1;
   logic [DATA_W-1:0] id_rdata2;
   logic [DATA_W-1:0] id_imm;
   logic              id_use_imm;

   logic              exmem_reg_write;
   logic [REG_AW-1:0] exmem_rd;
   logic [DATA_W-1:0] exmem_result;
   logic              memwb_reg_write;
   logic [REG_AW-1:0] memwb_rd;
   logic [DATA_W-1:0] memwb_result;

   logic              flush;
   logic              ex_ready;
   logic              ex_valid;
   logic [2:0]        ex_alu_op;
   logic [DATA_W-1:0] ex_data1;
   logic [DATA_W-1:0] ex_data2;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_reg_write;
   logic              hazard_stall;

   modport master (
      output in_valid, id_alu_op,
      output id_rs1, id_rs2, id_rd,
      output id_reg_write,
      output id_rdata1, id_rdata2,
      output id_imm, id_use_imm,
      output exmem_reg_write, exmem_rd,
      output exmem_result,
      output memwb_reg_write, memwb_rd,
      output memwb_result,
      output flush, ex_ready,
      input  in_ready, ex_valid,
      input  ex_alu_op, ex_data1, ex_data2,
      input  ex_rd, ex_reg_write,
      input  hazard_stall
   );

   modport slave (
      input  in_valid, id_alu_op,
      input  id_rs1, id_rs2, id_rd,
      input  id_reg_write,
      input  id_rdata1, id_rdata2,
      input  id_imm, id_use_imm,
      input  exmem_reg_write, exmem_rd,
      input  exmem_result,
      input  memwb_reg_write, memwb_rd,
      input  memwb_result,
      input  flush, ex_ready,
      output in_ready, ex_valid,
      output ex_alu_op, ex_data1, ex_data2,
      output ex_rd, ex_reg_write,
      output hazard_stall
   );

endinterface

// File: rtl/alu_issue_stage_fwd_mux.sv
// Per-source operand resolver; forwards EX/MEM then MEM/WB results
// only when ALU_ISSUE_FWD_EN is defined, always reports a producer hit.
module alu_fwd_mux
   import alu_pkg::*;
#(
   parameter int DATA_W = alu_pkg::DATA_W,
   parameter int REG_AW = alu_pkg::REG_AW
) (
   input  logic [REG_AW-1:0] rs,
   input  logic [DATA_W-1:0] rdata,
   input  logic              exmem_reg_write,
   input  logic [REG_AW-1:0] exmem_rd,
   input  logic [DATA_W-1:0] exmem_result,
   input  logic              memwb_reg_write,
   input  logic [REG_AW-1:0] memwb_rd,
   input  logic [DATA_W-1:0] memwb_result,
   output logic [DATA_W-1:0] data,
   output logic              hit
);

   logic rs_live;
   logic ex_hit;
   logic wb_hit;

   // x0 is hardwired zero, so it never has an in-flight producer
   assign rs_live = (rs != '0);
   assign ex_hit  = rs_live & exmem_reg_write
                  & (exmem_rd == rs);
   assign wb_hit  = rs_live & memwb_reg_write
                  & (memwb_rd == rs);
   assign hit     = ex_hit | wb_hit;

`ifdef ALU_ISSUE_FWD_EN
   always_comb begin
      data = rdata;
      unique case (1'b1)
         ex_hit:  data = exmem_result;
         wb_hit:  data = memwb_result;
         default: data = rdata;
      endcase
   end
`else
   logic unused_res;

   assign data       = rdata;
   assign unused_res = ^{exmem_result, memwb_result};
`endif

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: operand resolve + 2-entry skid buffer to the ALU.
// ALU_ISSUE_FWD_EN selects forwarding; otherwise RAW hazards stall.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int DATA_W = alu_pkg::DATA_W,
   parameter int REG_AW = alu_pkg::REG_AW
) (
   input logic         clk,
   input logic         rst,
   alu_issue_stage_if.slave bus
);

   typedef struct packed {
      logic [2:0]        alu_op;
      logic [DATA_W-1:0] data1;
      logic [DATA_W-1:0] data2;
      logic [REG_AW-1:0] rd;
      logic              reg_write;
   } entry_t;

   skid_state_e state;
   skid_state_e state_n;

   entry_t out_q;
   entry_t skid_q;
   entry_t cap;

   logic [DATA_W-1:0] op1;
   logic [DATA_W-1:0] op2;
   logic              hit1;
   logic              hit2;
   logic              stall;
   logic              ready;
   logic              fire;
   logic              load_out;
   logic              load_skid;
   logic              from_skid;

   alu_fwd_mux #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_fwd1 (
      .rs              (bus.id_rs1),
      .rdata           (bus.id_rdata1),
      .exmem_reg_write (bus.exmem_reg_write),
      .exmem_rd        (bus.exmem_rd),
      .exmem_result    (bus.exmem_result),
      .memwb_reg_write (bus.memwb_reg_write),
      .memwb_rd        (bus.memwb_rd),
      .memwb_result    (bus.memwb_result),
      .data            (op1),
      .hit             (hit1)
   );

   alu_fwd_mux #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_fwd2 (
      .rs              (bus.id_rs2),
      .rdata           (bus.id_rdata2),
      .exmem_reg_write (bus.exmem_reg_write),
      .exmem_rd        (bus.exmem_rd),
      .exmem_result    (bus.exmem_result),
      .memwb_reg_write (bus.memwb_reg_write),
      .memwb_rd        (bus.memwb_rd),
      .memwb_result    (bus.memwb_result),
      .data            (op2),
      .hit             (hit2)
   );

`ifdef ALU_ISSUE_FWD_EN
   logic unused_hit;

   assign stall      = 1'b0;
   assign unused_hit = hit1 | hit2;
`else
   // rs2 only matters when the immediate is not selected
   assign stall = ~rst & bus.in_valid
                & (hit1 | (hit2 & ~bus.id_use_imm));
`endif

   always_comb begin
      cap.alu_op    = bus.id_alu_op;
      cap.data1     = op1;
      cap.data2     = bus.id_use_imm ? bus.id_imm : op2;
      cap.rd        = bus.id_rd;
      cap.reg_write = bus.id_reg_write;
   end

   assign ready = (state != ST_TWO) & ~stall;
   assign fire  = bus.in_valid & ready;

   always_comb begin
      state_n   = state;
      load_out  = 1'b0;
      load_skid = 1'b0;
      from_skid = 1'b0;
      if (bus.flush) begin
         state_n = ST_EMPTY;
      end else begin
         unique case (state)
            ST_EMPTY: begin
               if (fire) begin
                  state_n  = ST_ONE;
                  load_out = 1'b1;
               end
            end
            ST_ONE: begin
               if (fire && bus.ex_ready) begin
                  load_out = 1'b1;
               end else if (fire) begin
                  state_n   = ST_TWO;
                  load_skid = 1'b1;
               end else if (bus.ex_ready) begin
                  state_n = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (bus.ex_ready) begin
                  state_n   = ST_ONE;
                  load_out  = 1'b1;
                  from_skid = 1'b1;
               end
            end
            default: state_n = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_n;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q  <= '0;
         skid_q <= '0;
      end else begin
         if (load_out) begin
            out_q <= from_skid ? skid_q : cap;
         end
         if (load_skid) begin
            skid_q <= cap;
         end
      end
   end

   assign bus.in_ready     = ready;
   assign bus.hazard_stall = stall;
   assign bus.ex_valid     = (state != ST_EMPTY);
   assign bus.ex_alu_op    = out_q.alu_op;
   assign bus.ex_data1     = out_q.data1;
   assign bus.ex_data2     = out_q.data2;
   assign bus.ex_rd        = out_q.rd;
   assign bus.ex_reg_write = out_q.reg_write;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage against a queue-based model.
// Expectations follow ALU_ISSUE_FWD_EN the same way the design does.
module tb_alu_issue_stage;

   logic clk;
   logic rst;

   alu_issue_stage_if bus ();

   alu_issue_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [4:0]  rd;
      logic        rw;
   } ent_t;

   ent_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   wire [72:0] ex_bundle = {bus.ex_alu_op, bus.ex_data1,
                            bus.ex_data2, bus.ex_rd,
                            bus.ex_reg_write};

   function automatic logic busy(input logic [4:0] rs);
      return rs != 0 &&
             ((bus.exmem_reg_write && bus.exmem_rd == rs) ||
              (bus.memwb_reg_write && bus.memwb_rd == rs));
   endfunction

   function automatic logic [31:0] ref_fwd(input logic [4:0] rs,
                                           input logic [31:0] rf);
`ifdef ALU_ISSUE_FWD_EN
      if (rs != 0 && bus.exmem_reg_write && bus.exmem_rd == rs)
         return bus.exmem_result;
      if (rs != 0 && bus.memwb_reg_write && bus.memwb_rd == rs)
         return bus.memwb_result;
`endif
      return rf;
   endfunction

   function automatic logic ref_stall();
`ifdef ALU_ISSUE_FWD_EN
      return 1'b0;
`else
      return bus.in_valid &&
             (busy(bus.id_rs1) ||
              (!bus.id_use_imm && busy(bus.id_rs2)));
`endif
   endfunction

   function automatic logic ref_ready();
      return q.size() < 2 && !ref_stall();
   endfunction

   function automatic logic [72:0] head();
      return {q[0].op, q[0].d1, q[0].d2, q[0].rd, q[0].rw};
   endfunction

   task automatic drive_idle();
      bus.in_valid        = 0;
      bus.id_alu_op       = 0;
      bus.id_rs1          = 0;
      bus.id_rs2          = 0;
      bus.id_rd           = 0;
      bus.id_reg_write    = 0;
      bus.id_rdata1       = 0;
      bus.id_rdata2       = 0;
      bus.id_imm          = 0;
      bus.id_use_imm      = 0;
      bus.exmem_reg_write = 0;
      bus.exmem_rd        = 0;
      bus.exmem_result    = 0;
      bus.memwb_reg_write = 0;
      bus.memwb_rd        = 0;
      bus.memwb_result    = 0;
      bus.flush           = 0;
      bus.ex_ready        = 0;
   endtask

   // advance one clock and the model together (no DUT reads)
   task automatic tick();
      logic f;
      logic pop;
      logic fl;
      ent_t e;
      f    = bus.in_valid && ref_ready();
      pop  = q.size() > 0 && bus.ex_ready;
      fl   = bus.flush;
      e.op = bus.id_alu_op;
      e.d1 = ref_fwd(bus.id_rs1, bus.id_rdata1);
      e.d2 = bus.id_use_imm ? bus.id_imm
                            : ref_fwd(bus.id_rs2, bus.id_rdata2);
      e.rd = bus.id_rd;
      e.rw = bus.id_reg_write;
      @(posedge clk);
      if (fl) begin
         q.delete();
      end else begin
         if (pop) void'(q.pop_front());
         if (f) q.push_back(e);
      end
      #1;
   endtask

   task automatic test_reset();
      drive_idle();
      rst = 1;
      bus.in_valid = 1;
      bus.id_rdata1 = 32'h1234;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (bus.ex_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_valid got %b exp 0", bus.ex_valid);
      end
      n_checks++;
      if (ex_bundle !== 73'd0) begin
         n_errors++;
         $display("FAIL reset_outputs got %h exp 0", ex_bundle);
      end
      n_checks++;
      if (bus.hazard_stall !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_stall got %b exp 0", bus.hazard_stall);
      end
      drive_idle();
      rst = 0;
      q.delete();
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_in_ready got %b exp 1", bus.in_ready);
      end
   endtask

   task automatic test_single_add();
      drive_idle();
      bus.in_valid     = 1;
      bus.id_alu_op    = 3'b000;
      bus.id_rs1       = 1;
      bus.id_rs2       = 2;
      bus.id_rd        = 6;
      bus.id_reg_write = 1;
      bus.id_rdata1    = 5;
      bus.id_rdata2    = 7;
      tick();
      bus.in_valid = 0;
      #1;
      n_checks++;
      if (ex_bundle !== {3'b000, 32'd5, 32'd7, 5'd6, 1'b1}
          || bus.ex_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL add got v=%b %h exp v=1 add 5 7 rd6",
                  bus.ex_valid, ex_bundle);
      end
      bus.ex_ready = 1;
      tick();
      n_checks++;
      if (bus.ex_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL add_drain got %b exp 0", bus.ex_valid);
      end
   endtask

   task automatic test_fwd_priority();
      drive_idle();
      bus.ex_ready        = 1;
      bus.in_valid        = 1;
      bus.id_alu_op       = 3'b110;
      bus.id_rs1          = 3;
      bus.id_rdata1       = 32'h11;
      bus.id_rdata2       = 32'h22;
      bus.exmem_reg_write = 1;
      bus.exmem_rd        = 3;
      bus.exmem_result    = 32'hAA;
      bus.memwb_reg_write = 1;
      bus.memwb_rd        = 3;
      bus.memwb_result    = 32'hBB;
      #1;
`ifdef ALU_ISSUE_FWD_EN
      n_checks++;
      if (bus.hazard_stall !== 1'b0) begin
         n_errors++;
         $display("FAIL fwd_nostall got %b exp 0", bus.hazard_stall);
      end
      tick();
      n_checks++;
      if (bus.ex_data1 !== 32'hAA) begin
         n_errors++;
         $display("FAIL fwd_exmem got %h exp aa", bus.ex_data1);
      end
      bus.id_rs1    = 0;
      bus.id_rdata1 = 32'h33;
      tick();
      n_checks++;
      if (bus.ex_data1 !== 32'h33) begin
         n_errors++;
         $display("FAIL fwd_x0 got %h exp 33", bus.ex_data1);
      end
      bus.id_rs1          = 3;
      bus.exmem_reg_write = 0;
      tick();
      n_checks++;
      if (bus.ex_data1 !== 32'hBB) begin
         n_errors++;
         $display("FAIL fwd_memwb got %h exp bb", bus.ex_data1);
      end
`else
      n_checks++;
      if (bus.hazard_stall !== 1'b1 || bus.in_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL haz_both got stall=%b rdy=%b exp 1 0",
                  bus.hazard_stall, bus.in_ready);
      end
      tick();
      n_checks++;
      if (bus.ex_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL haz_noaccept got %b exp 0", bus.ex_valid);
      end
      bus.exmem_reg_write = 0;
      #1;
      n_checks++;
      if (bus.hazard_stall !== 1'b1) begin
         n_errors++;
         $display("FAIL haz_memwb got %b exp 1", bus.hazard_stall);
      end
      bus.memwb_reg_write = 0;
      #1;
      n_checks++;
      if (bus.hazard_stall !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL haz_clear got stall=%b rdy=%b exp 0 1",
                  bus.hazard_stall, bus.in_ready);
      end
      tick();
      n_checks++;
      if (bus.ex_data1 !== 32'h11 || bus.ex_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL haz_accept got v=%b %h exp 1 11",
                  bus.ex_valid, bus.ex_data1);
      end
      bus.id_rs1          = 0;
      bus.id_rdata1       = 32'h33;
      bus.exmem_reg_write = 1;
      bus.exmem_rd        = 0;
      bus.memwb_reg_write = 1;
      bus.memwb_rd        = 0;
      #1;
      n_checks++;
      if (bus.hazard_stall !== 1'b0) begin
         n_errors++;
         $display("FAIL haz_x0 got %b exp 0", bus.hazard_stall);
      end
      tick();
      n_checks++;
      if (bus.ex_data1 !== 32'h33) begin
         n_errors++;
         $display("FAIL haz_x0_data got %h exp 33", bus.ex_data1);
      end
`endif
      drive_idle();
      bus.ex_ready = 1;
      tick();
   endtask

   task automatic test_backpressure();
      drive_idle();
      bus.in_valid     = 1;
      bus.id_reg_write = 1;
      for (int i = 0; i < 3; i++) begin
         bus.id_alu_op = 3'(i);
         bus.id_rdata1 = 32'(256 + i);
         bus.id_rdata2 = 32'(512 + i);
         bus.id_rd     = 5'(i + 1);
         #1;
         n_checks++;
         if (bus.in_ready !== (i < 2)) begin
            n_errors++;
            $display("FAIL bp_ready[%0d] got %b exp %b",
                     i, bus.in_ready, (i < 2));
         end
         tick();
      end
      bus.in_valid = 0;
      bus.ex_ready = 1;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (ex_bundle !== {3'(i), 32'(256 + i), 32'(512 + i),
                            5'(i + 1), 1'b1}) begin
            n_errors++;
            $display("FAIL bp_order[%0d] got %h", i, ex_bundle);
         end
         tick();
      end
      n_checks++;
      if (bus.ex_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL bp_empty got %b exp 0", bus.ex_valid);
      end
   endtask

   task automatic test_imm();
      drive_idle();
      bus.ex_ready        = 1;
      bus.in_valid        = 1;
      bus.id_alu_op       = 3'b010;
      bus.id_rs2          = 4;
      bus.id_rd           = 9;
      bus.id_rdata1       = 9;
      bus.id_rdata2       = 32'h77;
      bus.id_imm          = 32'hFFFF_FFF0;
      bus.id_use_imm      = 1;
      bus.exmem_reg_write = 1;
      bus.exmem_rd        = 4;
      bus.exmem_result    = 32'h55;
      #1;
      n_checks++;
      if (bus.hazard_stall !== 1'b0) begin
         n_errors++;
         $display("FAIL imm_stall got %b exp 0", bus.hazard_stall);
      end
      tick();
      n_checks++;
      if (ex_bundle !== {3'b010, 32'd9, 32'hFFFF_FFF0,
                         5'd9, 1'b0}) begin
         n_errors++;
         $display("FAIL imm_data got %h", ex_bundle);
      end
      bus.id_use_imm = 0;
      #1;
`ifdef ALU_ISSUE_FWD_EN
      tick();
      n_checks++;
      if (bus.ex_data2 !== 32'h55) begin
         n_errors++;
         $display("FAIL imm_rs2_fwd got %h exp 55", bus.ex_data2);
      end
`else
      n_checks++;
      if (bus.hazard_stall !== 1'b1) begin
         n_errors++;
         $display("FAIL imm_rs2_haz got %b exp 1", bus.hazard_stall);
      end
`endif
      drive_idle();
      bus.ex_ready = 1;
      tick();
   endtask

   task automatic test_flush();
      drive_idle();
      bus.in_valid  = 1;
      bus.id_rdata1 = 32'hF1;
      tick();
      tick();
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.ex_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL flush_full got rdy=%b v=%b exp 0 1",
                  bus.in_ready, bus.ex_valid);
      end
      bus.flush = 1;
      tick();
      bus.flush    = 0;
      bus.in_valid = 0;
      #1;
      n_checks++;
      if (bus.ex_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL flush_empty got v=%b rdy=%b exp 0 1",
                  bus.ex_valid, bus.in_ready);
      end
      tick();
      n_checks++;
      if (bus.ex_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL flush_dropped got %b exp 0", bus.ex_valid);
      end
   endtask

   task automatic test_async_reset();
      drive_idle();
      bus.in_valid     = 1;
      bus.id_rdata1    = 32'hC0;
      bus.id_rdata2    = 32'hC1;
      bus.id_reg_write = 1;
      tick();
      tick();
      #2;
      rst = 1;
      #1;
      n_checks++;
      if (bus.ex_valid !== 1'b0 || ex_bundle !== 73'd0) begin
         n_errors++;
         $display("FAIL areset got v=%b %h exp 0 0",
                  bus.ex_valid, ex_bundle);
      end
      q.delete();
      bus.in_valid = 0;
      @(negedge clk);
      rst = 0;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.ex_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL areset_release got v=%b rdy=%b exp 0 1",
                  bus.ex_valid, bus.in_ready);
      end
   endtask

   task automatic test_random();
      drive_idle();
      for (int c = 0; c < 400; c++) begin
         bus.in_valid        = $urandom_range(0, 3) != 0;
         bus.ex_ready        = $urandom_range(0, 1) == 1;
         bus.flush           = $urandom_range(0, 19) == 0;
         bus.id_alu_op       = 3'($urandom);
         bus.id_rs1          = 5'($urandom_range(0, 3));
         bus.id_rs2          = 5'($urandom_range(0, 3));
         bus.id_rd           = 5'($urandom);
         bus.id_reg_write    = 1'($urandom);
         bus.id_rdata1       = $urandom;
         bus.id_rdata2       = $urandom;
         bus.id_imm          = $urandom;
         bus.id_use_imm      = 1'($urandom);
         bus.exmem_reg_write = 1'($urandom);
         bus.exmem_rd        = 5'($urandom_range(0, 3));
         bus.exmem_result    = $urandom;
         bus.memwb_reg_write = 1'($urandom);
         bus.memwb_rd        = 5'($urandom_range(0, 3));
         bus.memwb_result    = $urandom;
         #1;
         n_checks++;
         if (bus.in_ready !== ref_ready() ||
             bus.hazard_stall !== ref_stall()) begin
            n_errors++;
            $display("FAIL rnd_ctrl[%0d] got rdy=%b st=%b exp %b %b",
                     c, bus.in_ready, bus.hazard_stall,
                     ref_ready(), ref_stall());
         end
         n_checks++;
         if (bus.ex_valid !== (q.size() != 0)) begin
            n_errors++;
            $display("FAIL rnd_valid[%0d] got %b exp %b",
                     c, bus.ex_valid, (q.size() != 0));
         end
         if (q.size() != 0) begin
            n_checks++;
            if (ex_bundle !== head()) begin
               n_errors++;
               $display("FAIL rnd_data[%0d] got %h exp %h",
                        c, ex_bundle, head());
            end
         end
         tick();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1;
      drive_idle();
      test_reset();
      test_single_add();
      test_fwd_priority();
      test_backpressure();
      test_imm();
      test_flush();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
